boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_pkg.sv | 24 ++
 rtl/boot_timeout.sv | 32 +++
 rtl/boot_loader_ctrl.sv | 177 +++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and protocol byte values for the serial boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_RUN,
    ST_REPLY
  } boot_state_e;

  localparam logic [7:0] BYTE_SYNC  = 8'h55;
  localparam logic [7:0] BYTE_LOAD  = 8'h01;
  localparam logic [7:0] BYTE_RUN   = 8'h02;
  localparam logic [7:0] BYTE_STAT  = 8'h03;
  localparam logic [7:0] BYTE_ACK   = 8'h06;
  localparam logic [7:0] BYTE_NAK   = 8'h15;
  localparam logic [7:0] BYTE_ABORT = 8'h1B;
  localparam logic [7:0] BYTE_CAN   = 8'h18;

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte watchdog: down-counter reloaded on clr or while idle,
// expired flags the terminal count while enabled.
module boot_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Reload while disabled or on every received byte, otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= CNT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Serial boot loader: parses SYNC-prefixed frames from the UART, writes
// program words, releases/holds the core and returns one reply byte per command.
//
// state      | meaning
// IDLE       | waiting for SYNC, other bytes ignored
// CMD        | waiting for command byte
// LEN        | waiting for word count
// DATA_HI    | waiting for high byte of next word
// DATA_LO    | waiting for low byte, completes and writes the word
// CSUM       | waiting for XOR checksum of all data bytes
// RUN        | core released, waiting for halt/done or ABORT
// REPLY      | holding tx byte until the transmitter takes it
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [15:0]          mem_wdata,
  output logic                 cpu_rst,
  input  logic                 cpu_halt,
  input  logic                 cpu_done,
  output logic                 busy,
  output logic                 err
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  boot_state_e state;
  logic [7:0]  word_cnt;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic        tmo_en;
  logic        tmo_expired;

  assign tmo_en = state inside {ST_CMD, ST_LEN, ST_DATA_HI, ST_DATA_LO, ST_CSUM};

  boot_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rx_valid),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Frame parser, memory write path, core hold and reply handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cpu_rst   <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
      hi_byte   <= '0;
      csum      <= '0;
    end else begin
      mem_we <= 1'b0;
      err    <= 1'b0;
      // Address advances after the write cycle so mem_addr is valid alongside mem_we.
      if (mem_we) mem_addr <= mem_addr + ADDR_ONE;

      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_data == BYTE_SYNC) begin
            state <= ST_CMD;
            busy  <= 1'b1;
          end
        end
        ST_CMD: begin
          if (rx_valid) begin
            case (rx_data)
              BYTE_LOAD: state <= ST_LEN;
              BYTE_RUN: begin
                state   <= ST_RUN;
                cpu_rst <= 1'b0;
              end
              BYTE_STAT: begin
                state    <= ST_REPLY;
                tx_data  <= {6'b0, cpu_halt, cpu_done};
                tx_valid <= 1'b1;
              end
              default: begin
                state    <= ST_REPLY;
                tx_data  <= BYTE_NAK;
                tx_valid <= 1'b1;
              end
            endcase
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            csum     <= '0;
            word_cnt <= rx_data;
            if (rx_data == 8'd0) begin
              state <= ST_CSUM;
            end else begin
              mem_addr <= '0;
              state    <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (rx_valid) begin
            hi_byte <= rx_data;
            csum    <= csum ^ rx_data;
            state   <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (rx_valid) begin
            mem_wdata <= {hi_byte, rx_data};
            mem_we    <= 1'b1;
            csum      <= csum ^ rx_data;
            word_cnt  <= word_cnt - 8'd1;
            state     <= (word_cnt == 8'd1) ? ST_CSUM : ST_DATA_HI;
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            state    <= ST_REPLY;
            tx_data  <= (rx_data == csum) ? BYTE_ACK : BYTE_NAK;
            tx_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          // A halted/finished core takes priority over a simultaneous ABORT.
          if (cpu_halt || cpu_done) begin
            cpu_rst  <= 1'b1;
            state    <= ST_REPLY;
            tx_data  <= {6'b100000, cpu_halt, cpu_done};
            tx_valid <= 1'b1;
          end else if (rx_valid && rx_data == BYTE_ABORT) begin
            cpu_rst  <= 1'b1;
            state    <= ST_REPLY;
            tx_data  <= BYTE_CAN;
            tx_valid <= 1'b1;
          end
        end
        ST_REPLY: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A byte arriving on the expiry cycle is processed above and restarts the count.
      if (tmo_expired && !rx_valid) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl with a short timeout and a 4-word memory.
module tb_boot_loader_ctrl;

  localparam int ADDR_BITS   = 2;
  localparam int TIMEOUT_CYC = 100;

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [15:0]          mem_wdata;
  logic                 cpu_rst;
  logic                 cpu_halt;
  logic                 cpu_done;
  logic                 busy;
  logic                 err;

  int checks = 0;
  int errors = 0;

  int         wr_cnt  = 0;
  int         tx_cnt  = 0;
  int         err_cnt = 0;
  logic [7:0] tx_last = 8'h00;
  logic [7:0]  wr_addr_log [0:31];
  logic [15:0] wr_data_log [0:31];

  boot_loader_ctrl #(
    .ADDR_BITS   (ADDR_BITS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .cpu_halt  (cpu_halt),
    .cpu_done  (cpu_done),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log memory writes, accepted reply bytes and error pulses.
  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr_log[wr_cnt[4:0]] <= 8'(mem_addr);
      wr_data_log[wr_cnt[4:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (tx_valid && tx_ready) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data;
    end
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_load(input logic [7:0] cs);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    check("we_after_lo", 32'(mem_we), 1);
    check("we_addr0", 32'(mem_addr), 0);
    check("we_data0", 32'(mem_wdata), 32'h1234);
    check("load_cpu_rst", 32'(cpu_rst), 1);
    @(negedge clk);
    check("we_one_cycle", 32'(mem_we), 0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(cs);
  endtask

  initial begin
    int         b_wr;
    int         b_tx;
    int         b_err;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] cs;

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    cpu_halt = 1'b0;
    cpu_done = 1'b0;

    // reset values
    idle(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;

    // IDLE ignores non-SYNC; unknown command answered with NAK
    send_byte(8'h01);
    check("idle_ignore", 32'(busy), 0);
    send_byte(8'h55);
    check("sync_busy", 32'(busy), 1);
    send_byte(8'h07);
    check("bad_cmd_txv", 32'(tx_valid), 1);
    check("bad_cmd_txd", 32'(tx_data), 32'h15);
    @(negedge clk);
    check("bad_cmd_txcnt", tx_cnt, 1);
    check("bad_cmd_txv_off", 32'(tx_valid), 0);
    check("bad_cmd_idle", 32'(busy), 0);

    // load with good checksum 0x40
    b_wr = wr_cnt;
    b_tx = tx_cnt;
    send_load(8'h40);
    check("good_txv", 32'(tx_valid), 1);
    check("good_txd", 32'(tx_data), 32'h06);
    idle(2);
    check("good_txcnt", tx_cnt, b_tx + 1);
    check("good_ack", 32'(tx_last), 32'h06);
    check("good_wrcnt", wr_cnt, b_wr + 2);
    check("good_a0", 32'(wr_addr_log[b_wr]), 0);
    check("good_d0", 32'(wr_data_log[b_wr]), 32'h1234);
    check("good_a1", 32'(wr_addr_log[b_wr + 1]), 1);
    check("good_d1", 32'(wr_data_log[b_wr + 1]), 32'hABCD);
    check("good_cpu_rst", 32'(cpu_rst), 1);
    check("good_idle", 32'(busy), 0);

    // same frame, bad checksum 0x41
    b_wr = wr_cnt;
    b_tx = tx_cnt;
    send_load(8'h41);
    idle(2);
    check("bad_txcnt", tx_cnt, b_tx + 1);
    check("bad_nak", 32'(tx_last), 32'h15);
    check("bad_wrcnt", wr_cnt, b_wr + 2);
    check("bad_a1", 32'(wr_addr_log[b_wr + 1]), 1);

    // STAT with stalled transmitter
    cpu_halt = 1'b1;
    tx_ready = 1'b0;
    b_tx = tx_cnt;
    send_byte(8'h55);
    send_byte(8'h03);
    for (int i = 0; i < 20; i++) begin
      check("stall_hold", {23'b0, tx_valid, tx_data}, 32'h102);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check("stat_txcnt", tx_cnt, b_tx + 1);
    check("stat_byte", 32'(tx_last), 32'h02);
    check("stat_txv_off", 32'(tx_valid), 0);
    cpu_halt = 1'b0;

    // reset during a stalled reply drops the reply
    cpu_done = 1'b1;
    tx_ready = 1'b0;
    b_tx = tx_cnt;
    send_byte(8'h55);
    send_byte(8'h03);
    check("stat2_txd", 32'(tx_data), 32'h01);
    rst_n = 1'b0;
    #1;
    check("rst_reply_txv", 32'(tx_valid), 0);
    check("rst_reply_txd", 32'(tx_data), 0);
    check("rst_reply_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    cpu_done = 1'b0;
    idle(2);
    check("rst_reply_none", tx_cnt, b_tx);

    // RUN until cpu_done
    b_tx = tx_cnt;
    send_byte(8'h55);
    send_byte(8'h02);
    check("run_release", 32'(cpu_rst), 0);
    check("run_busy", 32'(busy), 1);
    idle(49);
    check("run_held", 32'(cpu_rst), 0);
    cpu_done = 1'b1;
    @(negedge clk);
    check("done_cpu_rst", 32'(cpu_rst), 1);
    check("done_txv", 32'(tx_valid), 1);
    check("done_txd", 32'(tx_data), 32'h81);
    cpu_done = 1'b0;
    @(negedge clk);
    check("done_txcnt", tx_cnt, b_tx + 1);
    check("done_byte", 32'(tx_last), 32'h81);

    // RUN ignores other bytes, is exempt from timeout, ABORT cancels
    b_tx  = tx_cnt;
    b_err = err_cnt;
    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'h55);
    check("run_ignore", 32'(cpu_rst), 0);
    idle(120);
    check("run_no_tmo", err_cnt, b_err);
    check("run_still", 32'(busy), 1);
    send_byte(8'h1B);
    check("abort_cpu_rst", 32'(cpu_rst), 1);
    check("abort_txd", 32'(tx_data), 32'h18);
    idle(2);
    check("abort_txcnt", tx_cnt, b_tx + 1);

    // inter-byte timeout mid-word
    b_tx  = tx_cnt;
    b_wr  = wr_cnt;
    b_err = err_cnt;
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h12);
    idle(99);
    check("tmo_early_err", 32'(err), 0);
    check("tmo_early_busy", 32'(busy), 1);
    @(negedge clk);
    check("tmo_err", 32'(err), 1);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_cpu_rst", 32'(cpu_rst), 1);
    @(negedge clk);
    check("tmo_err_pulse", 32'(err), 0);
    check("tmo_err_cnt", err_cnt, b_err + 1);
    check("tmo_no_reply", tx_cnt, b_tx);
    check("tmo_no_write", wr_cnt, b_wr);

    // byte arriving on the expiry cycle wins; N=0 goes straight to checksum
    b_tx  = tx_cnt;
    b_err = err_cnt;
    send_byte(8'h55);
    send_byte(8'h01);
    idle(98);
    send_byte(8'h00);
    check("race_no_err", err_cnt, b_err);
    check("race_busy", 32'(busy), 1);
    send_byte(8'h00);
    idle(2);
    check("zero_len_ack", 32'(tx_last), 32'h06);
    check("zero_len_txcnt", tx_cnt, b_tx + 1);

    // 5-word load into 4-word memory wraps the address
    b_wr = wr_cnt;
    cs   = 8'h00;
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h05);
    for (int i = 0; i < 5; i++) begin
      hi = 8'hA0 + 8'(i);
      lo = 8'h50 + 8'(i * 3);
      cs = cs ^ hi ^ lo;
      send_byte(hi);
      send_byte(lo);
    end
    send_byte(cs);
    idle(2);
    check("wrap_ack", 32'(tx_last), 32'h06);
    check("wrap_wrcnt", wr_cnt, b_wr + 5);
    for (int i = 0; i < 5; i++) begin
      check("wrap_addr", 32'(wr_addr_log[b_wr + i]), 32'(i % 4));
      check("wrap_data", 32'(wr_data_log[b_wr + i]), 32'({8'hA0 + 8'(i), 8'h50 + 8'(i * 3)}));
    end

    // reset in DATA_LO with the low byte arriving: no write
    b_wr = wr_cnt;
    b_tx = tx_cnt;
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hAA);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_data  = 8'hBB;
    rx_valid = 1'b1;
    #1;
    check("rst_lo_we", 32'(mem_we), 0);
    check("rst_lo_busy", 32'(busy), 0);
    check("rst_lo_wdata", 32'(mem_wdata), 0);
    check("rst_lo_cpu_rst", 32'(cpu_rst), 1);
    @(negedge clk);
    check("rst_lo_no_write", wr_cnt, b_wr);
    // first byte after reset release is taken on the next edge
    rst_n    = 1'b1;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("post_rst_sync", 32'(busy), 1);
    send_byte(8'h03);
    idle(2);
    check("post_rst_stat", 32'(tx_last), 32'h00);
    check("post_rst_txcnt", tx_cnt, b_tx + 1);
    check("post_rst_wrcnt", wr_cnt, b_wr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
